// File: rtl/pool_pkg.sv
// Shared types and defaults for the max-pool address generator.
// The cfg struct is the geometry snapshot taken when a job starts.
package pool_pkg;

    localparam int POOL_ADD_SIZE = 20;
    localparam int POOL_DIM_W    = 8;
    localparam int POOL_CH_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_e;

    typedef struct packed {
        logic [POOL_DIM_W-1:0] img_w;
        logic [POOL_DIM_W-1:0] img_h;
        logic [POOL_DIM_W-1:0] win;
        logic [POOL_DIM_W-1:0] stride;
        logic [POOL_CH_W-1:0]  channels;
    } pool_cfg_t;

    function automatic logic cfg_illegal(input pool_cfg_t cfg);
        return (cfg.win == '0) || (cfg.stride == '0) ||
               (cfg.channels == '0) ||
               (cfg.win > cfg.img_w) || (cfg.win > cfg.img_h);
    endfunction

endpackage

// File: rtl/pool_window_counter.sv
// Nested kx/ky/c0/r0/c counter chain for the pooling walk.
// Wrap flags describe the current position; step_i advances one beat.
module pool_window_counter
    import pool_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  step_i,
    input  pool_cfg_t             cfg_i,
    output logic [POOL_DIM_W-1:0] c0_o,
    output logic                  kx_last_o,
    output logic                  ky_last_o,
    output logic                  col_wrap_o,
    output logic                  row_wrap_o,
    output logic                  ch_last_o
);

    localparam int DW = POOL_DIM_W;
    localparam int CW = POOL_CH_W;

    logic [DW-1:0] kx_q, kx_d;
    logic [DW-1:0] ky_q, ky_d;
    logic [DW-1:0] c0_q, c0_d;
    logic [DW-1:0] r0_q, r0_d;
    logic [CW-1:0] c_q, c_d;

    logic [DW:0] col_sum;
    logic [DW:0] row_sum;

    // One extra bit keeps origin+stride+win from wrapping.
    always_comb begin
        col_sum    = {1'b0, c0_q} + {1'b0, cfg_i.stride} + {1'b0, cfg_i.win};
        row_sum    = {1'b0, r0_q} + {1'b0, cfg_i.stride} + {1'b0, cfg_i.win};
        kx_last_o  = (kx_q == cfg_i.win - DW'(1));
        ky_last_o  = (ky_q == cfg_i.win - DW'(1));
        col_wrap_o = (col_sum > {1'b0, cfg_i.img_w});
        row_wrap_o = (row_sum > {1'b0, cfg_i.img_h});
        ch_last_o  = (c_q == cfg_i.channels - CW'(1));
        c0_o       = c0_q;
    end

    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        c0_d = c0_q;
        r0_d = r0_q;
        c_d  = c_q;
        if (clear_i) begin
            kx_d = '0;
            ky_d = '0;
            c0_d = '0;
            r0_d = '0;
            c_d  = '0;
        end else if (step_i) begin
            if (!kx_last_o) begin
                kx_d = kx_q + DW'(1);
            end else begin
                kx_d = '0;
                if (!ky_last_o) begin
                    ky_d = ky_q + DW'(1);
                end else begin
                    ky_d = '0;
                    if (!col_wrap_o) begin
                        c0_d = c0_q + cfg_i.stride;
                    end else begin
                        c0_d = '0;
                        if (!row_wrap_o) begin
                            r0_d = r0_q + cfg_i.stride;
                        end else begin
                            r0_d = '0;
                            c_d  = c_q + CW'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kx_q <= '0;
            ky_q <= '0;
            c0_q <= '0;
            r0_q <= '0;
            c_q  <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            c0_q <= c0_d;
            r0_q <= r0_d;
            c_q  <= c_d;
        end
    end

endmodule

// File: rtl/max_pool_addr_gen.sv
// Max-pool address generator: FSM, valid/ready handshake and the
// plane/row/column address accumulators driven by the window counter.
module max_pool_addr_gen
    import pool_pkg::*;
#(
    parameter int ADD_SIZE = POOL_ADD_SIZE,
    parameter int DIM_W    = POOL_DIM_W,
    parameter int CH_W     = POOL_CH_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADD_SIZE-1:0] add_in,
    input  logic [DIM_W-1:0]    img_w,
    input  logic [DIM_W-1:0]    img_h,
    input  logic [DIM_W-1:0]    win,
    input  logic [DIM_W-1:0]    stride,
    input  logic [CH_W-1:0]     channels,
    output logic [ADD_SIZE-1:0] add_out,
    output logic                add_valid,
    input  logic                add_ready,
    output logic                window_last,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int AW = ADD_SIZE;

    pool_state_e state_q, state_d;
    pool_cfg_t   cfg_q, cfg_d;
    logic        err_q, err_d;

    logic [AW-1:0] row_step_q, row_step_d;
    logic [AW-1:0] plane_step_q, plane_step_d;
    logic [AW-1:0] plane_q, plane_d;
    logic [AW-1:0] orow_q, orow_d;
    logic [AW-1:0] rowb_q, rowb_d;
    logic [AW-1:0] addr_q, addr_d;

    logic [2*DIM_W-1:0] rs_prod;
    logic [2*DIM_W-1:0] ps_prod;

    logic [POOL_DIM_W-1:0] c0;
    logic kx_last, ky_last, col_wrap, row_wrap, ch_last;
    logic start_acc, beat, final_beat, cfg_bad;
    logic [AW-1:0] img_w_a, c0_a, stride_a, next_orow, next_plane;

    pool_window_counter u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (start_acc),
        .step_i    (beat),
        .cfg_i     (cfg_q),
        .c0_o      (c0),
        .kx_last_o (kx_last),
        .ky_last_o (ky_last),
        .col_wrap_o(col_wrap),
        .row_wrap_o(row_wrap),
        .ch_last_o (ch_last)
    );

    // One-time setup products; every per-beat step is an add.
    assign rs_prod = {{DIM_W{1'b0}}, stride} * {{DIM_W{1'b0}}, img_w};
    assign ps_prod = {{DIM_W{1'b0}}, img_h} * {{DIM_W{1'b0}}, img_w};

    assign start_acc  = (state_q == ST_IDLE) && start;
    assign beat       = add_valid && add_ready;
    assign final_beat = beat && kx_last && ky_last && col_wrap &&
                        row_wrap && ch_last;
    assign cfg_bad    = cfg_illegal(cfg_q);

    assign img_w_a    = AW'(cfg_q.img_w);
    assign c0_a       = AW'(c0);
    assign stride_a   = AW'(cfg_q.stride);
    assign next_orow  = orow_q + row_step_q;
    assign next_plane = plane_q + plane_step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: state_d = cfg_bad ? ST_DONE : ST_RUN;
            ST_RUN:   if (final_beat) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        add_valid   = (state_q == ST_RUN);
        busy        = (state_q == ST_CHECK) || (state_q == ST_RUN);
        done        = (state_q == ST_DONE);
        window_last = add_valid && kx_last && ky_last;
    end

    always_comb begin
        cfg_d        = cfg_q;
        err_d        = err_q;
        row_step_d   = row_step_q;
        plane_step_d = plane_step_q;
        plane_d      = plane_q;
        orow_d       = orow_q;
        rowb_d       = rowb_q;
        addr_d       = addr_q;
        if (start_acc) begin
            cfg_d.img_w    = img_w;
            cfg_d.img_h    = img_h;
            cfg_d.win      = win;
            cfg_d.stride   = stride;
            cfg_d.channels = channels;
            row_step_d     = AW'(rs_prod);
            plane_step_d   = AW'(ps_prod);
            plane_d        = add_in;
            orow_d         = add_in;
            rowb_d         = add_in;
            addr_d         = add_in;
            err_d          = 1'b0;
        end else if ((state_q == ST_CHECK) && cfg_bad) begin
            err_d = 1'b1;
        end else if (beat) begin
            if (!kx_last) begin
                addr_d = addr_q + AW'(1);
            end else if (!ky_last) begin
                rowb_d = rowb_q + img_w_a;
                addr_d = rowb_q + img_w_a + c0_a;
            end else if (!col_wrap) begin
                rowb_d = orow_q;
                addr_d = orow_q + c0_a + stride_a;
            end else if (!row_wrap) begin
                orow_d = next_orow;
                rowb_d = next_orow;
                addr_d = next_orow;
            end else begin
                plane_d = next_plane;
                orow_d  = next_plane;
                rowb_d  = next_plane;
                addr_d  = next_plane;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q        <= '0;
            err_q        <= 1'b0;
            row_step_q   <= '0;
            plane_step_q <= '0;
            plane_q      <= '0;
            orow_q       <= '0;
            rowb_q       <= '0;
            addr_q       <= '0;
        end else begin
            cfg_q        <= cfg_d;
            err_q        <= err_d;
            row_step_q   <= row_step_d;
            plane_step_q <= plane_step_d;
            plane_q      <= plane_d;
            orow_q       <= orow_d;
            rowb_q       <= rowb_d;
            addr_q       <= addr_d;
        end
    end

    assign add_out = addr_q;
    assign err     = err_q;

endmodule

// File: tb/tb_max_pool_addr_gen.sv
// Bench for max_pool_addr_gen: directed cases plus randomized jobs
// checked against a nested-loop reference of the pooling walk.
module tb_max_pool_addr_gen;

    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [19:0] add_in = '0;
    logic [7:0]  img_w = '0;
    logic [7:0]  img_h = '0;
    logic [7:0]  win = '0;
    logic [7:0]  stride = '0;
    logic [5:0]  channels = '0;
    logic        add_ready = 1'b1;
    logic [19:0] add_out;
    logic        add_valid, window_last, busy, done, err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [19:0] exp_a[$], obs_a[$], stall_a[$];
    logic        exp_l[$], obs_l[$], stall_l[$];
    bit          model_bad, timed_out;
    int          done_cyc, first_valid, last_beat;
    logic        err_done, busy_first;

    max_pool_addr_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .add_in     (add_in),
        .img_w      (img_w),
        .img_h      (img_h),
        .win        (win),
        .stride     (stride),
        .channels   (channels),
        .add_out    (add_out),
        .add_valid  (add_valid),
        .add_ready  (add_ready),
        .window_last(window_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Reference walk straight from the address formula.
    task automatic build_model(input int w, h, k, s, ch,
                               input logic [19:0] base);
        logic [63:0] a;
        exp_a.delete();
        exp_l.delete();
        model_bad = (k == 0) || (s == 0) || (ch == 0) || (k > w) || (k > h);
        if (model_bad) return;
        for (int c = 0; c < ch; c++)
            for (int r0 = 0; r0 + k <= h; r0 += s)
                for (int c0 = 0; c0 + k <= w; c0 += s)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            a = 64'(base) + 64'(c * w * h) +
                                64'((r0 + ky) * w) + 64'(c0 + kx);
                            exp_a.push_back(a[19:0]);
                            exp_l.push_back((kx == k - 1) && (ky == k - 1));
                        end
    endtask

    // Drives one job and records every accepted beat.
    task automatic run_job(input int w, h, k, s, ch,
                           input logic [19:0] base,
                           input bit rnd, input int stall_at,
                           input int stall_len);
        int n, left;
        obs_a.delete(); obs_l.delete();
        stall_a.delete(); stall_l.delete();
        done_cyc = -1; first_valid = -1; last_beat = -1;
        timed_out = 0; left = stall_len;
        @(posedge clk); #1;
        img_w = 8'(w); img_h = 8'(h); win = 8'(k);
        stride = 8'(s); channels = 6'(ch); add_in = base;
        start = 1'b1; add_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        img_w = 8'($urandom); img_h = 8'($urandom); win = 8'($urandom);
        stride = 8'($urandom); channels = 6'($urandom);
        add_in = 20'($urandom);
        n = 1;
        busy_first = busy;
        while (n <= LIMIT) begin
            if (done) begin
                done_cyc = n;
                err_done = err;
                break;
            end
            if (add_valid && first_valid < 0) first_valid = n;
            if (add_valid && left > 0 && obs_a.size() == stall_at) begin
                add_ready = 1'b0;
                left--;
                stall_a.push_back(add_out);
                stall_l.push_back(window_last);
            end else begin
                add_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (add_valid && add_ready) begin
                obs_a.push_back(add_out);
                obs_l.push_back(window_last);
                last_beat = n;
            end
            @(posedge clk); #1;
            n++;
        end
        add_ready = 1'b1;
        tests_run++;
        if (n > LIMIT) begin
            timed_out = 1;
            tests_failed++;
            $display("FAIL job_timeout: no done within %0d cycles", LIMIT);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({add_out, add_valid, window_last, busy, done, err} !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got add_out=%0d v=%b wl=%b busy=%b done=%b err=%b, want all 0",
                     add_out, add_valid, window_last, busy, done, err);
        end
        reset = 1'b0;
    endtask

    task automatic test_4x4;
        int tbl[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        int bad = -1;
        run_job(4, 4, 2, 2, 1, 20'd0, 0, -1, 0);
        tests_run++;
        if (obs_a.size() != 16) begin
            tests_failed++;
            $display("FAIL 4x4_count: got %0d beats, want 16", obs_a.size());
        end
        for (int i = 0; i < obs_a.size() && i < 16; i++)
            if (bad < 0 && (obs_a[i] !== 20'(tbl[i]) || obs_l[i] !== (i % 4 == 3)))
                bad = i;
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL 4x4_seq: beat %0d got addr=%0d last=%b, want addr=%0d last=%b",
                     bad, obs_a[bad], obs_l[bad], tbl[bad], (bad % 4 == 3));
        end
        tests_run++;
        if (first_valid != 2 || busy_first !== 1'b1) begin
            tests_failed++;
            $display("FAIL 4x4_first_valid: got cycle %0d busy=%b, want cycle 2 busy=1",
                     first_valid, busy_first);
        end
        tests_run++;
        if (done_cyc != 18 || last_beat != 17 || err_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL 4x4_done: got done=%0d last=%0d err=%b, want done=18 last=17 err=0",
                     done_cyc, last_beat, err_done);
        end
    endtask

    task automatic test_3x3;
        int tbl[16] = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};
        int bad = -1;
        run_job(3, 3, 2, 1, 1, 20'd0, 0, -1, 0);
        if (obs_a.size() != 16) bad = 99;
        for (int i = 0; i < obs_a.size() && i < 16; i++)
            if (bad < 0 && obs_a[i] !== 20'(tbl[i])) bad = i;
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL 3x3_seq: mismatch at %0d of %0d beats, want 16 beats 0,1,3,4/...",
                     bad, obs_a.size());
        end
    endtask

    task automatic test_two_channel;
        int bad = -1;
        int edge_hits = 0;
        build_model(5, 5, 2, 2, 2, 20'd100);
        run_job(5, 5, 2, 2, 2, 20'd100, 0, -1, 0);
        if (obs_a.size() != 32 || exp_a.size() != 32) bad = 99;
        for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++)
            if (bad < 0 && (obs_a[i] !== exp_a[i] || obs_l[i] !== exp_l[i])) bad = i;
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL 2ch_seq: mismatch at %0d, got %0d beats, want 32", bad, obs_a.size());
        end
        tests_run++;
        if (obs_a.size() < 17 || obs_a[12] !== 20'd112 || obs_a[13] !== 20'd113 ||
            obs_a[14] !== 20'd117 || obs_a[15] !== 20'd118 || obs_a[16] !== 20'd125) begin
            tests_failed++;
            $display("FAIL 2ch_boundary: channel 0 tail / channel 1 head wrong, want 112,113,117,118 then 125");
        end
        foreach (obs_a[i]) begin
            int off = (int'(obs_a[i]) - 100) % 25;
            if (off % 5 == 4 || off / 5 == 4) edge_hits++;
        end
        tests_run++;
        if (edge_hits != 0) begin
            tests_failed++;
            $display("FAIL 2ch_ragged: got %0d addresses in row/col 4, want 0", edge_hits);
        end
    endtask

    task automatic test_backpressure;
        int tbl[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        int bad = -1;
        run_job(4, 4, 2, 2, 1, 20'd0, 0, 5, 3);
        tests_run++;
        if (stall_a.size() != 3 || stall_a[0] !== 20'd3 || stall_a[1] !== 20'd3 ||
            stall_a[2] !== 20'd3 || stall_l[0] !== 1'b0 || stall_l[1] !== 1'b0 ||
            stall_l[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d stall samples (first addr=%0d), want 3 samples addr=3 last=0",
                     stall_a.size(), stall_a.size() > 0 ? int'(stall_a[0]) : -1);
        end
        if (obs_a.size() != 16) bad = 99;
        for (int i = 0; i < obs_a.size() && i < 16; i++)
            if (bad < 0 && obs_a[i] !== 20'(tbl[i])) bad = i;
        tests_run++;
        if (bad >= 0 || done_cyc != 21) begin
            tests_failed++;
            $display("FAIL bp_seq: mismatch %0d, %0d beats, done at %0d, want 16 beats done at 21",
                     bad, obs_a.size(), done_cyc);
        end
    endtask

    task automatic test_error;
        run_job(4, 4, 2, 0, 1, 20'd0, 0, -1, 0);
        tests_run++;
        if (obs_a.size() != 0 || first_valid != -1 || done_cyc != 2 || err_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_stride0: beats=%0d valid@%0d done@%0d err=%b, want 0,-1,2,1",
                     obs_a.size(), first_valid, done_cyc, err_done);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: got err=%b in idle, want 1", err);
        end
        run_job(4, 4, 5, 1, 1, 20'd0, 0, -1, 0);
        tests_run++;
        if (obs_a.size() != 0 || done_cyc != 2 || err_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_win5: beats=%0d done@%0d err=%b, want 0,2,1",
                     obs_a.size(), done_cyc, err_done);
        end
        run_job(4, 4, 2, 2, 1, 20'd0, 0, -1, 0);
        tests_run++;
        if (obs_a.size() != 16 || err_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear: beats=%0d err=%b, want 16 and 0", obs_a.size(), err_done);
        end
    endtask

    task automatic test_reset_midrun;
        int tbl[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        int got = 0;
        int n = 0;
        int dones = 0;
        int bad = -1;
        @(posedge clk); #1;
        img_w = 8'd4; img_h = 8'd4; win = 8'd2; stride = 8'd2;
        channels = 6'd1; add_in = 20'd0; start = 1'b1; add_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(add_valid && got == 4) && n < 100) begin
            if (add_valid) got++;
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (n >= 100 || add_out !== 20'd2) begin
            tests_failed++;
            $display("FAIL midrun_beat5: got addr=%0d after %0d cycles, want 2", add_out, n);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({add_out, add_valid, window_last, busy, done, err} !== 25'd0) begin
            tests_failed++;
            $display("FAIL midrun_async: got add_out=%0d v=%b busy=%b done=%b, want all 0",
                     add_out, add_valid, busy, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++;
            $display("FAIL midrun_no_done: got %0d done pulses, want 0", dones);
        end
        run_job(4, 4, 2, 2, 1, 20'd0, 0, -1, 0);
        if (obs_a.size() != 16) bad = 99;
        for (int i = 0; i < obs_a.size() && i < 16; i++)
            if (bad < 0 && obs_a[i] !== 20'(tbl[i])) bad = i;
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL midrun_restart: mismatch %0d, %0d beats, want full 16-beat sequence",
                     bad, obs_a.size());
        end
    endtask

    task automatic test_random;
        for (int j = 0; j < 25; j++) begin
            int w, h, k, s, ch, bad;
            logic [19:0] base;
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 8);
            k = $urandom_range(0, 5);
            s = $urandom_range(0, 4);
            ch = $urandom_range(0, 3);
            base = 20'($urandom);
            build_model(w, h, k, s, ch, base);
            run_job(w, h, k, s, ch, base, 1, -1, 0);
            bad = -1;
            if (obs_a.size() != exp_a.size()) bad = 9999;
            for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++)
                if (bad < 0 && (obs_a[i] !== exp_a[i] || obs_l[i] !== exp_l[i])) bad = i;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("FAIL rand_seq[%0d]: w=%0d h=%0d win=%0d s=%0d ch=%0d mismatch at %0d, got %0d beats, want %0d",
                         j, w, h, k, s, ch, bad, obs_a.size(), exp_a.size());
            end
            tests_run++;
            if (model_bad ? (done_cyc != 2 || err_done !== 1'b1)
                          : (done_cyc != last_beat + 1 || err_done !== 1'b0)) begin
                tests_failed++;
                $display("FAIL rand_done[%0d]: done@%0d last@%0d err=%b, want illegal=%b",
                         j, done_cyc, last_beat, err_done, model_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_3x3();
        test_two_channel();
        test_backpressure();
        test_error();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/max_pool_addr_gen.md
Name: max_pool_addr_gen

Overview:
- Parametrised address generator for the max-pool stage.
- Walks every pooling window of a multi-channel feature map stored row-major in memory, one element address per beat, over a valid/ready handshake.
- Sits between the layer controller, which supplies `start` and the geometry, and the feature-memory read port / max comparator.
- Supports runtime window size, stride and channel count, backpressure, ragged-edge truncation and an illegal-configuration error.

Parameters:
- ADD_SIZE, 20, width of memory addresses.
- DIM_W, 8, width of image width/height, window and stride fields.
- CH_W, 6, width of channel-count field.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- add_in  in  ADD_SIZE  base address of channel 0, pixel (0,0).
- img_w  in  DIM_W  feature-map width in pixels.
- img_h  in  DIM_W  feature-map height in pixels.
- win  in  DIM_W  square window side.
- stride  in  DIM_W  window step in both x and y.
- channels  in  CH_W  number of channel planes (0 is illegal).
- add_out  out  ADD_SIZE  current element address.
- add_valid  out  1  add_out is valid.
- add_ready  in  1  consumer accepts add_out this cycle.
- window_last  out  1  qualifies add_out as the final element of a window.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of job.
- err  out  1  sticky config-error flag; cleared by the next accepted start.

Behaviour:
- Reset (async, any state): state IDLE; add_out=0; add_valid=0; window_last=0; busy=0; done=0; err=0; all counters 0. A job in flight is abandoned with no done pulse.
- Geometry inputs are latched on the accepted start. Later changes to them are ignored until the next job.
- State IDLE:
  - start=1 → CHECK; latch geometry; busy=1; err=0.
  - start while busy is ignored.
- State CHECK (1 cycle):
  - Any of win=0, stride=0, channels=0, win>img_w or win>img_h → state DONE with err=1, no beats issued.
  - Otherwise → RUN.
  - The first add_valid rises 2 cycles after start.
- State RUN:
  - Loop order, outermost first: channel c, window origin row r0, window origin column c0, kernel row ky, kernel column kx.
  - add_out = add_in + c*img_w*img_h + (r0+ky)*img_w + (c0+kx), truncated to ADD_SIZE.
  - Implemented incrementally (plane, row and column base accumulators). No multipliers or dividers in the datapath.
  - A beat completes when add_valid && add_ready. While add_ready=0, add_out, add_valid and window_last hold stable.
  - One beat per cycle is sustained under continuous ready.
  - Counter advance on each completed beat:
    - kx wraps at win-1 into ky.
    - ky wraps at win-1 into c0 += stride.
    - If c0+stride+win > img_w, then c0=0 and r0 += stride.
    - If r0+stride+win > img_h, then r0=0 and c++.
    - Final beat: c=channels-1 at the last window element → DONE.
  - Ragged edges are truncated: output dims = floor((img-win)/stride)+1, with no partial windows.
  - window_last=1 exactly when kx=win-1 and ky=win-1.
- State DONE (1 cycle): done=1, busy=0, add_valid=0 → IDLE. A start arriving in DONE is ignored.
- Sizing: total beats = channels*out_h*out_w*win*win. Internal comparisons use DIM_W+1 bits to avoid wrap-around on c0+stride+win.

Decomposition:
- Shared package pool_pkg holds:
  - the state encoding (IDLE, CHECK, RUN, DONE);
  - default ADD_SIZE/DIM_W/CH_W constants;
  - a pool_cfg struct bundling img_w, img_h, win, stride, channels (reused by the comparator and controller).
- One natural sub-module: pool_window_counter, holding the kx/ky/c0/r0/c nested-counter chain with wrap flags. The top holds the FSM, handshake and address accumulators.

Test Plan:
- img 4x4, win=2, stride=2, channels=1, add_in=0, ready=1 → add_out sequence 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15. window_last high on every 4th beat. done pulses the cycle after beat 16; first valid 2 cycles after start.
- img 3x3, win=2, stride=1 → 16 beats: 0,1,3,4 / 1,2,4,5 / 3,4,6,7 / 4,5,7,8.
- img 5x5, win=2, stride=2, channels=2, add_in=100 → 32 beats. Channel 0 ends with 112,113,117,118; channel 1 starts at 125. Column 4 and row 4 are never addressed.
- Backpressure during the 4x4 case: hold add_ready=0 for 3 cycles at beat 6 → add_out=3 and window_last=0 held stable. The sequence resumes unchanged and the total stays 16 beats.
- stride=0 (or win=5 with a 4x4 image) → err=1, done pulse 2 cycles after start, add_valid never rises. A following legal start clears err.
- Assert reset mid-RUN at beat 5 → outputs zero immediately (async), no done pulse. A new start then reproduces the full sequence from 0.
